// File: rtl/dcache_assoc_pkg.sv
// Shared types for the set-associative data cache: CPU-side and memory-controller-side
// request/response records, the 128-bit line type and the controller state encoding.
package dcache_assoc_pkg;
   localparam int LINE_W   = 128;
   localparam int OFFSET_W = 4;

   typedef logic [31:0] word_t;
   typedef logic [31:0] addr_t;
   typedef logic [LINE_W/32-1:0][31:0] line_t;

   typedef struct packed {
      logic  valid;
      logic  rw;
      addr_t addr;
      word_t data;
      word_t wmask;
   } cpu_req_t;

   typedef struct packed {
      logic  ready;
      word_t data;
   } cpu_res_t;

   typedef struct packed {
      logic  valid;
      logic  rw;
      addr_t addr;
      line_t data;
   } mci_request_t;

   typedef struct packed {
      logic  ready;
      line_t data;
   } mci_response_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WRITEBACK,
      S_ALLOCATE,
      S_FLUSH
   } state_e;
endpackage

// File: rtl/dcache_lru_set.sv
// Per-set LRU ages: touching a way makes it age 0 and ages every younger way by one;
// the victim is the way holding the maximum age. Single-cycle update, no backpressure.
module dcache_lru_set #(
   parameter int WAYS = 2,
   parameter int SETS = 256
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [$clog2(SETS)-1:0]               set_i,
   input  logic                                  touch_i,
   input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] touch_way_i,
   output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] victim_o
);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic [WAY_W-1:0] age_q [SETS][WAYS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               age_q[s][w] <= WAY_W'(w);
            end
         end
      end else if (touch_i) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way_i) begin
               age_q[set_i][w] <= '0;
            end else if (age_q[set_i][w] < age_q[set_i][touch_way_i]) begin
               age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      victim_o = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (age_q[set_i][w] == WAY_W'(WAYS - 1)) begin
            victim_o = WAY_W'(w);
         end
      end
   end
endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back/write-allocate data cache with per-set LRU and a flush walker.
// Hit: ready 2 cycles after the request; misses stall the CPU (no queueing) until memory answers.
module dcache_assoc
   import dcache_assoc_pkg::*;
#(
   parameter int WAYS   = 2,
   parameter int SETS   = 256,
   parameter int ADDR_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  cpu_req_t      cpu_req,
   output cpu_res_t      cpu_res,
   output mci_request_t  mem_req,
   input  mci_response_t mem_res,
   input  logic          flush,
   output logic          flush_done
);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

   state_e           state_q, state_d;
   cpu_req_t         req_q, req_d;
   cpu_res_t         res_q, res_d;
   mci_request_t     mreq_q, mreq_d;
   logic             done_q, done_d, pend_q, pend_d, flushing_q, flushing_d;
   logic [IDX_W-1:0] fset_q, fset_d;
   logic [WAY_W-1:0] fway_q, fway_d, vway_q, vway_d;

   logic [TAG_W-1:0] tag_q  [WAYS][SETS];
   line_t            data_q [WAYS][SETS];
   logic [SETS-1:0]  valid_q [WAYS];
   logic [SETS-1:0]  dirty_q [WAYS];

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [1:0]       wsel;
   logic             hit, free_vld;
   logic [WAY_W-1:0] hit_way, free_way, lru_way, victim;
   line_t            hit_line;
   word_t            merged;

   logic             we_data, we_tag, we_valid, we_dirty, dirty_val;
   logic [WAY_W-1:0] wr_way;
   logic [IDX_W-1:0] wr_set;
   line_t            wr_line;
   logic             unused_bits;

   assign idx         = req_q.addr[OFFSET_W +: IDX_W];
   assign tag         = req_q.addr[ADDR_W-1 -: TAG_W];
   assign wsel        = req_q.addr[3:2];
   assign unused_bits = ^{req_q.valid, req_q.addr[1:0]};

   assign cpu_res    = res_q;
   assign mem_req    = mreq_q;
   assign flush_done = done_q;

   dcache_lru_set #(.WAYS(WAYS), .SETS(SETS)) u_lru (
      .clk        (clk),
      .rst        (rst),
      .set_i      (idx),
      .touch_i    (state_q == S_LOOKUP && hit),
      .touch_way_i(hit_way),
      .victim_o   (lru_way)
   );

   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      free_vld = 1'b0;
      free_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      // Descending scan so the lowest-index invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][idx]) begin
            free_vld = 1'b1;
            free_way = WAY_W'(w);
         end
      end
      victim   = free_vld ? free_way : lru_way;
      hit_line = data_q[hit_way][idx];
      merged   = (hit_line[wsel] & ~req_q.wmask) | (req_q.data & req_q.wmask);
   end

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      res_d        = '0;
      mreq_d       = mreq_q;
      mreq_d.valid = 1'b0;
      done_d       = 1'b0;
      pend_d       = pend_q | flush;
      flushing_d   = flushing_q;
      fset_d       = fset_q;
      fway_d       = fway_q;
      vway_d       = vway_q;
      we_data      = 1'b0;
      we_tag       = 1'b0;
      we_valid     = 1'b0;
      we_dirty     = 1'b0;
      dirty_val    = 1'b0;
      wr_way       = '0;
      wr_set       = '0;
      wr_line      = '0;

      case (state_q)
         S_IDLE: begin
            if (cpu_req.valid) begin
               req_d   = cpu_req;
               state_d = S_LOOKUP;
            end else if (pend_q || flush) begin
               pend_d     = 1'b0;
               flushing_d = 1'b1;
               fset_d     = '0;
               fway_d     = '0;
               state_d    = S_FLUSH;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               res_d.ready = 1'b1;
               res_d.data  = req_q.rw ? merged : hit_line[wsel];
               if (req_q.rw) begin
                  wr_line       = hit_line;
                  wr_line[wsel] = merged;
                  wr_way        = hit_way;
                  wr_set        = idx;
                  we_data       = 1'b1;
                  we_dirty      = 1'b1;
                  dirty_val     = 1'b1;
               end
               state_d = S_IDLE;
            end else begin
               vway_d = victim;
               if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
                  mreq_d.valid = 1'b1;
                  mreq_d.rw    = 1'b1;
                  mreq_d.addr  = '0;
                  mreq_d.addr[ADDR_W-1:OFFSET_W] = {tag_q[victim][idx], idx};
                  mreq_d.data  = data_q[victim][idx];
                  state_d      = S_WRITEBACK;
               end else begin
                  mreq_d.valid = 1'b1;
                  mreq_d.rw    = 1'b0;
                  mreq_d.addr  = {req_q.addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                  mreq_d.data  = '0;
                  state_d      = S_ALLOCATE;
               end
            end
         end
         S_WRITEBACK: begin
            if (mem_res.ready) begin
               if (flushing_q) begin
                  wr_way   = fway_q;
                  wr_set   = fset_q;
                  we_dirty = 1'b1;
                  state_d  = S_FLUSH;
               end else begin
                  mreq_d.valid = 1'b1;
                  mreq_d.rw    = 1'b0;
                  mreq_d.addr  = {req_q.addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                  mreq_d.data  = '0;
                  state_d      = S_ALLOCATE;
               end
            end
         end
         S_ALLOCATE: begin
            if (mem_res.ready) begin
               wr_way   = vway_q;
               wr_set   = idx;
               wr_line  = mem_res.data;
               we_data  = 1'b1;
               we_tag   = 1'b1;
               we_valid = 1'b1;
               we_dirty = 1'b1;
               state_d  = S_LOOKUP;
            end
         end
         S_FLUSH: begin
            pend_d = pend_q;
            // A line just written back comes round again clean and is then skipped.
            if (valid_q[fway_q][fset_q] && dirty_q[fway_q][fset_q]) begin
               mreq_d.valid = 1'b1;
               mreq_d.rw    = 1'b1;
               mreq_d.addr  = '0;
               mreq_d.addr[ADDR_W-1:OFFSET_W] = {tag_q[fway_q][fset_q], fset_q};
               mreq_d.data  = data_q[fway_q][fset_q];
               state_d      = S_WRITEBACK;
            end else if (fset_q == IDX_W'(SETS - 1) && fway_q == WAY_W'(WAYS - 1)) begin
               done_d     = 1'b1;
               flushing_d = 1'b0;
               state_d    = S_IDLE;
            end else if (fway_q == WAY_W'(WAYS - 1)) begin
               fway_d = '0;
               fset_d = fset_q + 1'b1;
            end else begin
               fway_d = fway_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         req_q      <= '0;
         res_q      <= '0;
         mreq_q     <= '0;
         done_q     <= 1'b0;
         pend_q     <= 1'b0;
         flushing_q <= 1'b0;
         fset_q     <= '0;
         fway_q     <= '0;
         vway_q     <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         res_q      <= res_d;
         mreq_q     <= mreq_d;
         done_q     <= done_d;
         pend_q     <= pend_d;
         flushing_q <= flushing_d;
         fset_q     <= fset_d;
         fway_q     <= fway_d;
         vway_q     <= vway_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
         end
      end else begin
         if (we_valid) valid_q[wr_way][wr_set] <= 1'b1;
         if (we_dirty) dirty_q[wr_way][wr_set] <= dirty_val;
      end
   end

   always_ff @(posedge clk) begin
      if (we_data) data_q[wr_way][wr_set] <= wr_line;
      if (we_tag)  tag_q[wr_way][wr_set]  <= tag;
   end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (2 ways, 256 sets) against a 3-cycle-latency memory model.
`timescale 1ns/1ps
module tb_dcache_assoc;
   import dcache_assoc_pkg::*;

   localparam int MEM_DELAY = 3;

   logic          clk = 1'b0;
   logic          rst;
   cpu_req_t      cpu_req;
   cpu_res_t      cpu_res;
   mci_request_t  mem_req;
   mci_response_t mem_res;
   logic          flush;
   logic          flush_done;

   always #5 clk = ~clk;

   dcache_assoc #(.WAYS(2), .SETS(256), .ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_res   (cpu_res),
      .mem_req   (mem_req),
      .mem_res   (mem_res),
      .flush     (flush),
      .flush_done(flush_done)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory model: logs every request pulse, answers each one MEM_DELAY cycles later.
   line_t mem [addr_t];
   int    rd_cnt = 0;
   int    wr_cnt = 0;
   addr_t rd_addr_log [$];
   addr_t wr_addr_log [$];
   line_t wr_data_log [$];
   int    dly = 0;
   addr_t pend_addr;

   initial begin
      mem_res = '0;
      forever begin
         @(negedge clk);
         mem_res.ready = 1'b0;
         if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               mem_res.ready = 1'b1;
               mem_res.data  = mem.exists(pend_addr) ? mem[pend_addr] : '0;
            end
         end
         if (mem_req.valid) begin
            if (mem_req.rw) begin
               wr_cnt++;
               wr_addr_log.push_back(mem_req.addr);
               wr_data_log.push_back(mem_req.data);
               mem[mem_req.addr] = mem_req.data;
            end else begin
               rd_cnt++;
               rd_addr_log.push_back(mem_req.addr);
            end
            pend_addr = mem_req.addr;
            dly       = MEM_DELAY;
         end
      end
   end

   task automatic do_req(input logic rw, input addr_t a, input word_t d, input word_t m,
                         output word_t rdata, output int lat);
      @(negedge clk);
      cpu_req.valid = 1'b1;
      cpu_req.rw    = rw;
      cpu_req.addr  = a;
      cpu_req.data  = d;
      cpu_req.wmask = m;
      @(negedge clk);
      cpu_req.valid = 1'b0;
      lat = 1;
      while (!cpu_res.ready && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!cpu_res.ready) lat = -1;
      rdata = cpu_res.data;
   endtask

   typedef struct {
      logic  rw;
      addr_t addr;
      word_t data;
      word_t mask;
      word_t exp;
      int    rd;
      int    wr;
      addr_t wb_addr;
      word_t wb_w0;
      int    lat;
   } vec_t;

   vec_t vecs [12];

   function automatic addr_t last_rd();
      return (rd_addr_log.size() > 0) ? rd_addr_log[rd_addr_log.size()-1] : '0;
   endfunction

   function automatic addr_t last_wr();
      return (wr_addr_log.size() > 0) ? wr_addr_log[wr_addr_log.size()-1] : '0;
   endfunction

   function automatic line_t last_wr_data();
      return (wr_data_log.size() > 0) ? wr_data_log[wr_data_log.size()-1] : '0;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      word_t rdata;
      int    lat, r0, w0, wl0, n;
      logic  quiet;
      line_t wl;

      rst = 1'b1;
      cpu_req = '0;
      flush = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_cpu_res", cpu_res, '0);
      check("reset_mem_req", mem_req, '0);
      check("reset_flush_done", flush_done, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_cpu_res", cpu_res, '0);
      check("post_reset_mem_valid", mem_req.valid, 1'b0);

      //          rw    addr          data          mask          exp           rd wr wb_addr       wb_w0         lat
      vecs[0]  = '{1'b0, 32'h0000_8000, 32'h0,        32'h0,        32'h0000_0000, 1, 0, 32'h0,        32'h0,        0};
      vecs[1]  = '{1'b0, 32'h0000_8000, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 32'h0,        32'h0,        2};
      vecs[2]  = '{1'b1, 32'h0000_8000, 32'hdeadbeef, 32'hffffffff, 32'hdeadbeef, 0, 0, 32'h0,        32'h0,        2};
      vecs[3]  = '{1'b0, 32'h0001_8000, 32'h0,        32'h0,        32'h0000_0000, 1, 0, 32'h0,        32'h0,        0};
      vecs[4]  = '{1'b0, 32'h0000_8000, 32'h0,        32'h0,        32'hdeadbeef, 0, 0, 32'h0,        32'h0,        2};
      vecs[5]  = '{1'b0, 32'h0002_8000, 32'h0,        32'h0,        32'h0000_0000, 1, 0, 32'h0,        32'h0,        0};
      vecs[6]  = '{1'b0, 32'h0003_8000, 32'h0,        32'h0,        32'h0000_0000, 1, 1, 32'h0000_8000, 32'hdeadbeef, 0};
      vecs[7]  = '{1'b1, 32'h0000_1230, 32'hba5eba11, 32'hffffffff, 32'hba5eba11, 1, 0, 32'h0,        32'h0,        0};
      vecs[8]  = '{1'b1, 32'h0000_1230, 32'h5e5e5e5e, 32'hffff0000, 32'h5e5eba11, 0, 0, 32'h0,        32'h0,        2};
      vecs[9]  = '{1'b0, 32'h0000_1230, 32'h0,        32'h0,        32'h5e5eba11, 0, 0, 32'h0,        32'h0,        2};
      vecs[10] = '{1'b1, 32'h0000_8004, 32'h12345678, 32'hffffffff, 32'h12345678, 1, 0, 32'h0,        32'h0,        0};
      vecs[11] = '{1'b0, 32'h0000_8000, 32'h0,        32'h0,        32'hdeadbeef, 0, 0, 32'h0,        32'h0,        2};

      for (int i = 0; i < 12; i++) begin
         r0 = rd_cnt;
         w0 = wr_cnt;
         do_req(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].mask, rdata, lat);
         check($sformatf("v%0d_ready", i), lat > 0, 1'b1);
         check($sformatf("v%0d_data", i), rdata, vecs[i].exp);
         check($sformatf("v%0d_reads", i), rd_cnt - r0, vecs[i].rd);
         check($sformatf("v%0d_writes", i), wr_cnt - w0, vecs[i].wr);
         if (vecs[i].lat > 0)
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         if (vecs[i].rd > 0)
            check($sformatf("v%0d_rd_addr", i), last_rd(), vecs[i].addr & 32'hffff_fff0);
         if (vecs[i].wr > 0) begin
            wl = last_wr_data();
            check($sformatf("v%0d_wb_addr", i), last_wr(), vecs[i].wb_addr);
            check($sformatf("v%0d_wb_word0", i), wl[0], vecs[i].wb_w0);
         end
      end

      // Flush: dirty lines at 0x08000 (set 0) and 0x1230 (set 0x23).
      r0  = rd_cnt;
      w0  = wr_cnt;
      wl0 = wr_addr_log.size();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n = 0;
      while (!flush_done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("flush_done_seen", flush_done, 1'b1);
      check("flush_writes", wr_cnt - w0, 2);
      check("flush_reads", rd_cnt - r0, 0);
      if (wr_addr_log.size() >= wl0 + 2) begin
         check("flush_wb0_addr", wr_addr_log[wl0], 32'h0000_8000);
         wl = wr_data_log[wl0];
         check("flush_wb0_word1", wl[1], 32'h12345678);
         check("flush_wb1_addr", wr_addr_log[wl0+1], 32'h0000_1230);
         wl = wr_data_log[wl0+1];
         check("flush_wb1_word0", wl[0], 32'h5e5eba11);
      end else begin
         check("flush_wb_logged", wr_addr_log.size() - wl0, 2);
      end
      @(negedge clk);
      check("flush_done_one_cycle", flush_done, 1'b0);

      r0 = rd_cnt;
      w0 = wr_cnt;
      do_req(1'b0, 32'h0000_1230, 32'h0, 32'h0, rdata, lat);
      check("post_flush_data", rdata, 32'h5e5eba11);
      check("post_flush_latency", lat, 2);
      check("post_flush_mem_traffic", (rd_cnt - r0) + (wr_cnt - w0), 0);

      // Reset in the middle of an allocate; the late response must be ignored.
      @(negedge clk);
      cpu_req.valid = 1'b1;
      cpu_req.rw    = 1'b0;
      cpu_req.addr  = 32'h0000_4000;
      @(negedge clk);
      cpu_req.valid = 1'b0;
      n = 0;
      while (!mem_req.valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_alloc_pulse_seen", mem_req.valid, 1'b1);
      check("rst_alloc_is_read", mem_req.rw, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_cpu_res", cpu_res, '0);
      check("rst_mid_mem_req", mem_req, '0);
      check("rst_mid_flush_done", flush_done, 1'b0);
      rst = 1'b0;
      quiet = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (cpu_res.ready || mem_req.valid || flush_done) quiet = 1'b0;
      end
      check("rst_stale_response_ignored", quiet, 1'b1);

      r0 = rd_cnt;
      w0 = wr_cnt;
      do_req(1'b0, 32'h0000_1230, 32'h0, 32'h0, rdata, lat);
      check("after_rst_ready", lat > 0, 1'b1);
      check("after_rst_reads", rd_cnt - r0, 1);
      check("after_rst_writes", wr_cnt - w0, 0);
      check("after_rst_rd_addr", last_rd(), 32'h0000_1230);
      check("after_rst_data", rdata, 32'h5e5eba11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
